// File: rtl/exe_mul_div_unit_pkg.sv
// Shared word length, mul/div operation encodings and FSM state encodings for the
// EXE-stage multiply/divide unit; the ID-stage decoder uses the same OP encodings.
package exe_mul_div_unit_pkg;

    localparam int unsigned WORD_LEN   = 32;
    localparam int unsigned CNT_W      = 6;
    localparam int unsigned ITERATIONS = WORD_LEN;

    typedef enum logic [1:0] {
        OpMultu = 2'b00,
        OpMult  = 2'b01,
        OpDivu  = 2'b10,
        OpDiv   = 2'b11
    } mul_div_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StCalc = 2'b01,
        StSign = 2'b10
    } mul_div_state_e;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mul_div_sign_fix.sv
// Sign handling around the unsigned iterative core: absolute values of the operands at
// load time, and negation of the product or of quotient/remainder at commit time.
module mul_div_sign_fix
    import exe_mul_div_unit_pkg::*;
#(
    parameter int unsigned W = WORD_LEN
) (
    input  logic [W-1:0]   op1,
    input  logic [W-1:0]   op2,
    input  logic           is_signed,
    output logic [W-1:0]   abs1,
    output logic [W-1:0]   abs2,
    output logic           sign_main,
    output logic           sign_rem,
    input  logic [2*W-1:0] acc,
    input  logic           is_div,
    input  logic           neg_main,
    input  logic           neg_rem,
    output logic [W-1:0]   res_hi,
    output logic [W-1:0]   res_lo
);

    logic [2*W-1:0] prod_neg;
    logic [W-1:0]   quot_neg;
    logic [W-1:0]   rem_neg;

    always_comb begin
        // The most negative value negates to itself and is then read as unsigned.
        abs1      = (is_signed && op1[W-1]) ? -op1 : op1;
        abs2      = (is_signed && op2[W-1]) ? -op2 : op2;
        sign_main = is_signed && (op1[W-1] ^ op2[W-1]);
        sign_rem  = is_signed && op1[W-1];

        prod_neg = -acc;
        quot_neg = -acc[W-1:0];
        rem_neg  = -acc[2*W-1:W];

        if (is_div) begin
            res_hi = neg_rem  ? rem_neg  : acc[2*W-1:W];
            res_lo = neg_main ? quot_neg : acc[W-1:0];
        end else begin
            res_hi = neg_main ? prod_neg[2*W-1:W] : acc[2*W-1:W];
            res_lo = neg_main ? prod_neg[W-1:0]   : acc[W-1:0];
        end
    end

endmodule

// File: rtl/exe_mul_div_unit.sv
// Iterative MIPS32 MULT/MULTU/DIV/DIVU unit: one bit per cycle over 32 cycles, a sign
// fix-up cycle, then commit to the architectural HI/LO registers.
module exe_mul_div_unit
    import exe_mul_div_unit_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic                START,
    input  logic [1:0]          OP,
    input  logic [WORD_LEN-1:0] OPERAND1,
    input  logic [WORD_LEN-1:0] OPERAND2,
    input  logic                MTHI_EN,
    input  logic                MTLO_EN,
    input  logic [WORD_LEN-1:0] MT_DATA,
    output logic                BUSY,
    output logic                DONE,
    output logic [WORD_LEN-1:0] HI,
    output logic [WORD_LEN-1:0] LO,
    output logic                DIV_ZERO
);

    localparam int unsigned W = WORD_LEN;

    mul_div_state_e   state_q;
    mul_div_op_e      op_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [2*W-1:0]   acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_main_q;
    logic             sign_rem_q;
    logic [W-1:0]     hi_q;
    logic [W-1:0]     lo_q;
    logic             done_q;
    logic             div_zero_q;

    logic [W-1:0]     abs1;
    logic [W-1:0]     abs2;
    logic             load_sign_main;
    logic             load_sign_rem;
    logic [W-1:0]     res_hi;
    logic [W-1:0]     res_lo;
    logic             is_div_q;

    logic [W-1:0]     mul_addend;
    logic [W:0]       mul_sum;
    logic [W:0]       div_shift;
    logic [W:0]       div_diff;
    logic             div_ok;
    logic [W-1:0]     div_rem;
    logic [2*W-1:0]   acc_next;

    assign is_div_q = op_is_div(op_q);

    // a_q holds the multiplier/divisor and b_q the multiplicand/dividend for both op kinds.
    mul_div_sign_fix #(
        .W (W)
    ) u_sign_fix (
        .op1       (OPERAND1),
        .op2       (OPERAND2),
        .is_signed (op_is_signed(OP)),
        .abs1      (abs1),
        .abs2      (abs2),
        .sign_main (load_sign_main),
        .sign_rem  (load_sign_rem),
        .acc       (acc_q),
        .is_div    (is_div_q),
        .neg_main  (sign_main_q),
        .neg_rem   (sign_rem_q),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

    always_comb begin
        mul_addend = b_q[0] ? a_q : {W{1'b0}};
        mul_sum    = {1'b0, acc_q[2*W-1:W]} + {1'b0, mul_addend};

        // Restoring divide: the remainder never exceeds the divisor, so bit W of the
        // difference is a clean borrow flag.
        div_shift = {acc_q[2*W-1:W], b_q[W-1]};
        div_diff  = div_shift - {1'b0, a_q};
        div_ok    = ~div_diff[W];
        div_rem   = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];

        if (is_div_q) begin
            acc_next = {div_rem, acc_q[W-2:0], div_ok};
        end else begin
            acc_next = {mul_sum, acc_q[W-1:1]};
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            op_q        <= OpMultu;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sign_main_q <= 1'b0;
            sign_rem_q  <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (MTHI_EN) hi_q <= MT_DATA;
                    if (MTLO_EN) lo_q <= MT_DATA;
                    if (START) begin
                        state_q     <= StCalc;
                        op_q        <= mul_div_op_e'(OP);
                        a_q         <= abs2;
                        b_q         <= abs1;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        sign_main_q <= load_sign_main;
                        sign_rem_q  <= load_sign_rem;
                        div_zero_q  <= op_is_div(OP) && (OPERAND2 == '0);
                    end
                end
                StCalc: begin
                    acc_q <= acc_next;
                    b_q   <= is_div_q ? {b_q[W-2:0], 1'b0} : {1'b0, b_q[W-1:1]};
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(ITERATIONS - 1)) state_q <= StSign;
                end
                StSign: begin
                    // Divide by zero: remainder path already yields OPERAND1; force LO.
                    hi_q    <= res_hi;
                    lo_q    <= (is_div_q && div_zero_q) ? {W{1'b1}} : res_lo;
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign BUSY     = (state_q != StIdle);
    assign DONE     = done_q;
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign DIV_ZERO = div_zero_q;

endmodule

// File: tb/tb_exe_mul_div_unit.sv
// Bench for exe_mul_div_unit: directed cases plus randomized ops against an arithmetic
// reference model.
module tb_exe_mul_div_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [31:0] OPERAND1 = '0;
    logic [31:0] OPERAND2 = '0;
    logic        MTHI_EN = 1'b0;
    logic        MTLO_EN = 1'b0;
    logic [31:0] MT_DATA = '0;
    logic        BUSY;
    logic        DONE;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        DIV_ZERO;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    exe_mul_div_unit dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .START    (START),
        .OP       (OP),
        .OPERAND1 (OPERAND1),
        .OPERAND2 (OPERAND2),
        .MTHI_EN  (MTHI_EN),
        .MTLO_EN  (MTLO_EN),
        .MT_DATA  (MT_DATA),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .HI       (HI),
        .LO       (LO),
        .DIV_ZERO (DIV_ZERO)
    );

    // Returns {div_zero, hi, lo} from plain MIPS arithmetic.
    function automatic logic [64:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] r;
        logic [63:0]        p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; return {1'b0, p}; end
            2'b01: begin p = sa * sb; return {1'b0, p}; end
            2'b10: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                return {1'b0, a % b, a / b};
            end
            default: begin
                if (b == 0) return {1'b1, a, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {1'b0, r[31:0], q[31:0]};
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            default: return $urandom();
        endcase
    endfunction

    // Call at a negedge with the unit idle; returns at the negedge where DONE is seen.
    task automatic start_and_wait(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo, output logic dz,
                                  output int busy_n, output int done_at);
        START = 1'b1; OP = op; OPERAND1 = a; OPERAND2 = b;
        @(posedge CLK); #1;
        START = 1'b0;
        busy_n = 0;
        done_at = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            if (BUSY) busy_n++;
            if (DONE) begin done_at = i; break; end
        end
        hi = HI; lo = LO; dz = DIV_ZERO;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", DONE); end
        n_cmp++; if (HI !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 0", HI); end
        n_cmp++; if (LO !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 0", LO); end
        n_cmp++; if (DIV_ZERO !== 1'b0) begin n_err++; $display("FAIL reset_dz: got %b want 0", DIV_ZERO); end
    endtask

    task automatic test_directed();
        logic [31:0] hi, lo;
        logic dz;
        int busy_n, done_at;
        @(negedge CLK);
        start_and_wait(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, hi, lo, dz, busy_n, done_at);
        n_cmp++; if (hi !== 32'hFFFFFFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_cmp++; if (lo !== 32'h00000001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        n_cmp++; if (done_at !== 34) begin n_err++; $display("FAIL multu_latency: got %0d want 34", done_at); end
        n_cmp++; if (busy_n !== 33) begin n_err++; $display("FAIL multu_busy_cycles: got %0d want 33", busy_n); end
        @(negedge CLK);
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b want 0", DONE); end
        n_cmp++; if (HI !== 32'hFFFFFFFE) begin n_err++; $display("FAIL hi_stable: got %h want fffffffe", HI); end

        @(negedge CLK);
        start_and_wait(2'b01, 32'hFFFFFFFD, 32'h5, hi, lo, dz, busy_n, done_at);
        n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin n_err++; $display("FAIL mult_neg: got %h_%h want ffffffff_fffffff1", hi, lo); end

        @(negedge CLK);
        start_and_wait(2'b11, 32'hFFFFFFF9, 32'h2, hi, lo, dz, busy_n, done_at);
        n_cmp++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin n_err++; $display("FAIL div_neg7_2: got %h_%h want ffffffff_fffffffd", hi, lo); end
        @(negedge CLK);
        start_and_wait(2'b11, 32'h80000000, 32'hFFFFFFFF, hi, lo, dz, busy_n, done_at);
        n_cmp++; if ({hi, lo} !== 64'h00000000_80000000) begin n_err++; $display("FAIL div_wrap: got %h_%h want 00000000_80000000", hi, lo); end

        @(negedge CLK);
        start_and_wait(2'b10, 32'h64, 32'h0, hi, lo, dz, busy_n, done_at);
        n_cmp++; if ({hi, lo} !== 64'h00000064_FFFFFFFF) begin n_err++; $display("FAIL divu_zero: got %h_%h want 00000064_ffffffff", hi, lo); end
        n_cmp++; if (dz !== 1'b1) begin n_err++; $display("FAIL divu_zero_flag: got %b want 1", dz); end
        n_cmp++; if (done_at !== 34) begin n_err++; $display("FAIL divu_zero_latency: got %0d want 34", done_at); end
        repeat (3) @(negedge CLK);
        n_cmp++; if (DIV_ZERO !== 1'b1) begin n_err++; $display("FAIL div_zero_hold: got %b want 1", DIV_ZERO); end
        start_and_wait(2'b00, 32'h3, 32'h4, hi, lo, dz, busy_n, done_at);
        n_cmp++; if (dz !== 1'b0) begin n_err++; $display("FAIL div_zero_clear: got %b want 0", dz); end
        n_cmp++; if ({hi, lo} !== 64'hC) begin n_err++; $display("FAIL multu_small: got %h_%h want 0_c", hi, lo); end
    endtask

    task automatic test_mt_busy();
        logic [64:0] exp;
        int done_at;
        exp = ref_model(2'b10, 32'd1000, 32'd7);
        @(negedge CLK);
        START = 1'b1; OP = 2'b10; OPERAND1 = 32'd1000; OPERAND2 = 32'd7;
        MTHI_EN = 1'b1; MT_DATA = 32'hCAFE0001;
        @(posedge CLK); #1;
        START = 1'b0; MTHI_EN = 1'b0;
        repeat (5) @(negedge CLK);
        START = 1'b1; OP = 2'b00; OPERAND1 = 32'hFFFF; OPERAND2 = 32'h3;
        MTHI_EN = 1'b1; MT_DATA = 32'hDEADBEEF;
        @(negedge CLK);
        START = 1'b0; MTHI_EN = 1'b0;
        n_cmp++; if (HI !== 32'hCAFE0001) begin n_err++; $display("FAIL mthi_busy_ignored: got %h want cafe0001", HI); end
        n_cmp++; if (BUSY !== 1'b1) begin n_err++; $display("FAIL busy_mid_op: got %b want 1", BUSY); end
        done_at = -1;
        for (int i = 7; i <= 40; i++) begin
            @(negedge CLK);
            if (DONE) begin done_at = i; break; end
        end
        n_cmp++; if (done_at !== 34) begin n_err++; $display("FAIL start_busy_latency: got %0d want 34", done_at); end
        n_cmp++; if ({HI, LO} !== exp[63:0]) begin n_err++; $display("FAIL start_busy_result: got %h_%h want %h", HI, LO, exp[63:0]); end
        MTLO_EN = 1'b1; MT_DATA = 32'h1234;
        @(negedge CLK);
        MTLO_EN = 1'b0;
        n_cmp++; if (LO !== 32'h1234) begin n_err++; $display("FAIL mtlo_idle: got %h want 00001234", LO); end
        n_cmp++; if (HI !== exp[63:32]) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want %h", HI, exp[63:32]); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo, a, b;
        logic [64:0] exp;
        logic dz;
        int busy_n, done_at;
        @(negedge CLK);
        START = 1'b1; OP = 2'b10; OPERAND1 = $urandom(); OPERAND2 = $urandom() | 32'h1;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (10) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        n_cmp++; if (BUSY !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got %b want 0", BUSY); end
        n_cmp++; if (DONE !== 1'b0) begin n_err++; $display("FAIL midreset_done: got %b want 0", DONE); end
        n_cmp++; if ({HI, LO} !== 64'h0) begin n_err++; $display("FAIL midreset_hilo: got %h_%h want 0_0", HI, LO); end
        a = pick(); b = pick();
        exp = ref_model(2'b01, a, b);
        start_and_wait(2'b01, a, b, hi, lo, dz, busy_n, done_at);
        n_cmp++; if ({hi, lo} !== exp[63:0] || done_at !== 34) begin n_err++; $display("FAIL after_reset_op: got %h_%h at %0d want %h at 34", hi, lo, done_at, exp[63:0]); end
    endtask

    task automatic test_random();
        logic [31:0] hi, lo, a, b;
        logic [1:0] op;
        logic [64:0] exp;
        logic dz;
        int busy_n, done_at;
        for (int n = 0; n < 24; n++) begin
            op = 2'($urandom_range(0, 3));
            a = pick(); b = pick();
            exp = ref_model(op, a, b);
            @(negedge CLK);
            start_and_wait(op, a, b, hi, lo, dz, busy_n, done_at);
            n_cmp++;
            if ({dz, hi, lo} !== exp || done_at !== 34) begin
                n_err++;
                $display("FAIL random op=%0d a=%h b=%h: got dz=%b %h_%h at %0d want %h at 34",
                         op, a, b, dz, hi, lo, done_at, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] hi, lo, a, b;
        logic [1:0] op;
        logic [64:0] exp;
        logic dz;
        int busy_n, done_at;
        @(negedge CLK);
        for (int n = 0; n < 4; n++) begin
            op = 2'($urandom_range(0, 3));
            a = pick(); b = pick();
            exp = ref_model(op, a, b);
            start_and_wait(op, a, b, hi, lo, dz, busy_n, done_at);
            n_cmp++;
            if ({dz, hi, lo} !== exp || done_at !== 34) begin
                n_err++;
                $display("FAIL back_to_back op=%0d a=%h b=%h: got dz=%b %h_%h at %0d want %h at 34",
                         op, a, b, dz, hi, lo, done_at, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mt_busy();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
